div_hilo_controller: RTL and testbench

Multicycle control stage wrapped around the combinational 32-bit signed non-restoring divider. It registers operands and holds them stable on the divider inputs for a fixed settle window. It then captures quotient into LO and remainder into HI, and handles divide-by-zero and signed overflow without using the divider. It sits between the datapath bus/ALU control, which issues `start`, and the HI/LO register consumers (mfhi/mflo paths).

---
 rtl/div_hilo_controller.sv | 135 +++++++++++++
 tb/tb_div_hilo_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/div_hilo_controller.sv
// div_hilo_controller: multicycle wrapper around a combinational signed divider.
// Registers operands onto the divider inputs, waits SETTLE_CYCLES clocks,
// then captures quotient into LO and remainder into HI. Divide-by-zero and the
// most-negative / -1 overflow case are resolved directly without the divider.
module div_hilo_controller #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [3:0]       CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic [WIDTH-1:0]   dividend_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
  logic               ovf_q;

  logic               is_zero_div;
  logic               is_overflow;

  // Special-case detection on the incoming operands.
  always_comb begin
    is_zero_div = (divisor_in == '0);
    is_overflow = (dividend_in == MOST_NEG) && (divisor_in == '1);
  end

  // Control FSM with registered busy/done and HI/LO/flag capture.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            dividend_q <= dividend_in;
            divisor_q  <= divisor_in;
            if (is_zero_div) begin
              hi_q    <= dividend_in;
              lo_q    <= '1;
              dbz_q   <= 1'b1;
              ovf_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (is_overflow) begin
              hi_q    <= '0;
              lo_q    <= MOST_NEG;
              dbz_q   <= 1'b0;
              ovf_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cnt_q   <= CNT_INIT;
              busy_q  <= 1'b1;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            lo_q    <= div_quotient;
            hi_q    <= div_remainder;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Drive outputs straight from the registers.
  always_comb begin
    div_dividend = dividend_q;
    div_divisor  = divisor_q;
    hi           = hi_q;
    lo           = lo_q;
    busy         = busy_q;
    done         = done_q;
    div_by_zero  = dbz_q;
    overflow     = ovf_q;
  end

endmodule

// File: tb/tb_div_hilo_controller.sv
// Testbench for div_hilo_controller: table-driven divide vectors plus
// hand-written reset and mid-operation sequences.
module tb_div_hilo_controller;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  logic         clk;
  logic         clr;
  logic         start;
  logic [W-1:0] dividend_in;
  logic [W-1:0] divisor_in;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;

  div_hilo_controller #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .dividend_in  (dividend_in),
    .divisor_in   (divisor_in),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .busy         (busy),
    .done         (done),
    .div_by_zero  (div_by_zero),
    .overflow     (overflow),
    .hi           (hi),
    .lo           (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational divider (truncating signed division).
  always_comb begin
    div_quotient  = '0;
    div_remainder = '0;
    if (div_divisor != '0 && !(div_dividend == 32'h8000_0000 && div_divisor == 32'hFFFF_FFFF)) begin
      div_quotient  = $signed(div_dividend) / $signed(div_divisor);
      div_remainder = $signed(div_dividend) % $signed(div_divisor);
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_lo;
    logic [W-1:0] exp_hi;
    logic         exp_dbz;
    logic         exp_ovf;
    int           exp_lat;
  } vec_t;

  // Issue one divide and verify busy/done timing plus results.
  task automatic run_op(input vec_t v, input string tag);
    int busy_n;
    int lat;
    bit done_seen;
    bit both;
    @(negedge clk);
    dividend_in = v.a;
    divisor_in  = v.b;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_n = 0; lat = -1; done_seen = 0; both = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy && done) both = 1;
      if (busy) busy_n++;
      if (done) begin
        done_seen = 1;
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, " done_seen"}, 32'(done_seen), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(v.exp_lat));
    check({tag, " busy_and_done"}, 32'(both), 32'd0);
    check({tag, " lo"}, lo, v.exp_lo);
    check({tag, " hi"}, hi, v.exp_hi);
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(v.exp_dbz));
    check({tag, " overflow"}, 32'(overflow), 32'(v.exp_ovf));
    check({tag, " div_dividend"}, div_dividend, v.a);
    check({tag, " div_divisor"}, div_divisor, v.b);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " div_dividend"}, div_dividend, '0);
    check({tag, " div_divisor"}, div_divisor, '0);
    check({tag, " hi"}, hi, '0);
    check({tag, " lo"}, lo, '0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'd0);
    check({tag, " overflow"}, 32'(overflow), 32'd0);
  endtask

  vec_t vecs[8];
  vec_t v;
  bit   done_hit;

  initial begin
    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, S};
    vecs[1] = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 1'b0, S};
    vecs[2] = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1, 1'b0, 0};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1, 0};
    vecs[4] = '{32'd10,         32'd3,          32'd3,          32'd1,          1'b0, 1'b0, S};
    vecs[5] = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0, S};
    vecs[6] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 1'b0, S};
    vecs[7] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 1'b0, S};

    // Reset with random inputs, including start.
    clr = 1'b1; start = 1'b1;
    dividend_in = $urandom; divisor_in = $urandom;
    done_hit = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (done) done_hit = 1;
      dividend_in = $urandom; divisor_in = $urandom;
    end
    check("reset done_pulse", 32'(done_hit), 32'd0);
    check_all_zero("reset");
    @(negedge clk);
    clr = 1'b0; start = 1'b0;

    // Table-driven divides.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Start pulsed during WAIT is ignored, then clr on the second WAIT cycle.
    @(negedge clk);
    dividend_in = 32'd100; divisor_in = 32'd7; start = 1'b1;
    @(posedge clk);                 // accepted here
    @(negedge clk);
    check("midop busy", 32'(busy), 32'd1);
    dividend_in = 32'd55; divisor_in = 32'd5;   // start still high: ignored in WAIT
    @(posedge clk);
    #1;
    start = 1'b0;
    check("midop ignored dividend", div_dividend, 32'd100);
    check("midop ignored divisor", div_divisor, 32'd7);
    check("midop still busy", 32'(busy), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midclr");
    @(negedge clk);
    clr = 1'b0;
    done_hit = 0;
    for (int i = 0; i < S + 2; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_hit = 1;
    end
    check("midclr no_done_no_busy", 32'(done_hit), 32'd0);
    check("midclr lo", lo, '0);

    // Start one cycle after clr deasserts completes normally.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    v = '{32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 1'b0, S};
    run_op(v, "post_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
